wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 25 ++
 rtl/wb_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_wb_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - result payload type and pipeline squash interface for wb_arbiter
//
// Purpose:
//   wb_arbiter_pkg : fu_output_t, the functional-unit result record carried
//                    unchanged from a source to the writeback port.
//   squash_if      : single-wire pipeline flush request.
//     valid  master -> slave  flush all buffered results this cycle

package wb_arbiter_pkg;

  typedef struct packed {
    logic [31:0] pc;     // program counter of the producing instruction
    logic [7:0]  id;     // instruction tag
    logic [5:0]  prd;    // physical destination register
    logic [63:0] rdval;  // result value
  } fu_output_t;

endpackage

interface squash_if;
  logic valid;

  modport master (output valid);
  modport slave  (input  valid);
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin writeback arbiter with per-source result FIFOs
//
// Purpose:
//   Buffers results from NB_FU functional units (which cannot be stalled) in
//   one small FIFO each and funnels them, one per cycle, into a single
//   register-file writeback port using round-robin arbitration.
//
// Ports:
//   clk               in   clock, rising edge
//   rstn              in   synchronous active-low reset
//   fuoutput_i        in   per-source result payload
//   fuoutput_i_valid  in   per-source result valid (no backpressure)
//   fu_almost_full_o  out  per-source: FIFO has at most one free entry
//   wb_o              out  granted result (head of the granted FIFO)
//   wb_o_valid        out  wb_o holds a result
//   wb_i_ready        in   writeback port accepts wb_o this cycle
//   wb_src_o          out  index of the granted source
//   overflow_o        out  sticky: a result was dropped on a full FIFO
//   squash_io         if   pipeline flush request (squash_io.valid)

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NB_FU      = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                           clk,
  input  logic                                           rstn,
  input  fu_output_t                                     fuoutput_i [NB_FU],
  input  logic [NB_FU-1:0]                               fuoutput_i_valid,
  output logic [NB_FU-1:0]                               fu_almost_full_o,
  output fu_output_t                                     wb_o,
  output logic                                           wb_o_valid,
  input  logic                                           wb_i_ready,
  output logic [((NB_FU > 1) ? $clog2(NB_FU) : 1)-1:0]   wb_src_o,
  output logic                                           overflow_o,
  squash_if.slave                                        squash_io
);

  localparam int SRC_W = (NB_FU > 1) ? $clog2(NB_FU) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  fu_output_t       mem    [NB_FU][FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr [NB_FU];
  logic [PTR_W-1:0] wr_ptr [NB_FU];
  logic [CNT_W-1:0] count  [NB_FU];

  logic [SRC_W-1:0] last_grant;
  // A stalled grant is pinned so a later arrival on a source earlier in the
  // round-robin order cannot steal the port while the head waits for ready.
  logic             lock_valid;
  logic [SRC_W-1:0] lock_idx;
  logic             overflow_q;

  // ---------------------------------------------------------------------------
  // Occupancy flags
  // ---------------------------------------------------------------------------
  logic [NB_FU-1:0] nonempty;
  logic [NB_FU-1:0] full;
  logic             squash;

  assign squash = squash_io.valid;

  always_comb begin
    nonempty         = '0;
    full             = '0;
    fu_almost_full_o = '0;
    for (int k = 0; k < NB_FU; k++) begin
      nonempty[k]         = (count[k] != '0);
      full[k]             = (count[k] == CNT_W'(FIFO_DEPTH));
      fu_almost_full_o[k] = (count[k] >= CNT_W'(FIFO_DEPTH - 1));
    end
  end

  // ---------------------------------------------------------------------------
  // Grant selection: pinned index if still pending, else round-robin search
  // starting just after the last source that completed a handshake.
  // ---------------------------------------------------------------------------
  logic [SRC_W-1:0] rr_grant;
  logic             rr_found;
  logic [SRC_W-1:0] grant;
  logic             any_valid;

  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    for (int i = 1; i <= NB_FU; i++) begin
      if (!rr_found && nonempty[SRC_W'((int'(last_grant) + i) % NB_FU)]) begin
        rr_grant = SRC_W'((int'(last_grant) + i) % NB_FU);
        rr_found = 1'b1;
      end
    end
  end

  assign any_valid = |nonempty;

  always_comb begin
    if (lock_valid && nonempty[lock_idx]) begin
      grant = lock_idx;
    end else begin
      grant = rr_grant;
    end
  end

  assign wb_o_valid = any_valid;
  assign wb_src_o   = grant;
  assign wb_o       = mem[grant][rd_ptr[grant]];
  assign overflow_o = overflow_q;

  // ---------------------------------------------------------------------------
  // Push / pop decisions
  // ---------------------------------------------------------------------------
  logic             handshake;
  logic [NB_FU-1:0] pop;
  logic [NB_FU-1:0] push;
  logic [NB_FU-1:0] drop;

  assign handshake = any_valid && wb_i_ready;

  always_comb begin
    pop  = '0;
    push = '0;
    drop = '0;
    for (int k = 0; k < NB_FU; k++) begin
      pop[k]  = handshake && !squash && (grant == SRC_W'(k));
      // A full FIFO still accepts when its head leaves in the same cycle.
      push[k] = fuoutput_i_valid[k] && !squash && (!full[k] || pop[k]);
      drop[k] = fuoutput_i_valid[k] && !squash && full[k] && !pop[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Payload storage (not reset; contents are qualified by count)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int k = 0; k < NB_FU; k++) begin
      if (rstn && push[k]) begin
        mem[k][wr_ptr[k]] <= fuoutput_i[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy, arbitration state, sticky overflow
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < NB_FU; k++) begin
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
        count[k]  <= '0;
      end
      last_grant <= SRC_W'(NB_FU - 1);
      lock_valid <= 1'b0;
      lock_idx   <= '0;
      overflow_q <= 1'b0;
    end else if (squash) begin
      // Flush: buffered results and this cycle's inputs vanish; the
      // round-robin position and the overflow history are kept.
      for (int k = 0; k < NB_FU; k++) begin
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
        count[k]  <= '0;
      end
      lock_valid <= 1'b0;
    end else begin
      for (int k = 0; k < NB_FU; k++) begin
        if (push[k]) begin
          wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
        end
        if (pop[k]) begin
          rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
        end
        case ({push[k], pop[k]})
          2'b10:   count[k] <= count[k] + CNT_W'(1);
          2'b01:   count[k] <= count[k] - CNT_W'(1);
          default: count[k] <= count[k];
        endcase
      end
      if (handshake) begin
        last_grant <= grant;
      end
      lock_valid <= any_valid && !wb_i_ready;
      lock_idx   <= grant;
      if (|drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed table-driven bench for wb_arbiter
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  fu_output_t  fu_in [4];
  logic [3:0]  fu_valid;
  logic [3:0]  af;
  fu_output_t  wb;
  logic        wb_valid;
  logic        wb_ready;
  logic [1:0]  src;
  logic        ovf;

  squash_if sq_if ();

  always #5 clk = ~clk;

  wb_arbiter #(.NB_FU(4), .FIFO_DEPTH(2)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .fuoutput_i       (fu_in),
    .fuoutput_i_valid (fu_valid),
    .fu_almost_full_o (af),
    .wb_o             (wb),
    .wb_o_valid       (wb_valid),
    .wb_i_ready       (wb_ready),
    .wb_src_o         (src),
    .overflow_o       (ovf),
    .squash_io        (sq_if)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        sq;
    logic [3:0]  v;
    logic [31:0] ids;   // {id3, id2, id1, id0}
    logic        rdy;
    logic        ev;
    logic [1:0]  esrc;
    logic [7:0]  eid;
    logic [3:0]  eaf;
    logic        eovf;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [NV];

  function automatic fu_output_t mk_fu(input logic [7:0] id);
    fu_output_t f;
    f.pc    = {24'h004000, id};
    f.id    = id;
    f.prd   = id[5:0] ^ 6'h2a;
    f.rdval = {8{id}} ^ 64'h0123456789abcdef;
    return f;
  endfunction

  function automatic vec_t mk(input logic sq, input logic [3:0] v, input logic [31:0] ids,
                              input logic rdy, input logic ev, input logic [1:0] esrc,
                              input logic [7:0] eid, input logic [3:0] eaf, input logic eovf);
    vec_t t;
    t.sq = sq; t.v = v; t.ids = ids; t.rdy = rdy;
    t.ev = ev; t.esrc = esrc; t.eid = eid; t.eaf = eaf; t.eovf = eovf;
    return t;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic sq, input logic [3:0] v,
                       input logic [31:0] ids, input logic rdy);
    @(negedge clk);
    rstn         = r;
    sq_if.valid  = sq;
    fu_valid     = v;
    wb_ready     = rdy;
    for (int k = 0; k < 4; k++) fu_in[k] = mk_fu(ids[8*k +: 8]);
  endtask

  initial begin
    // Round robin, backpressure with pinned grant, overflow, squash,
    // full FIFO push+pop in the same cycle.
    tbl[0]  = mk(0, 4'b1111, 32'h13121110, 1,  0, 0, 8'h00, 4'b0000, 0);
    tbl[1]  = mk(0, 4'b0000, 32'h0,        1,  1, 0, 8'h10, 4'b1111, 0);
    tbl[2]  = mk(0, 4'b0000, 32'h0,        1,  1, 1, 8'h11, 4'b1110, 0);
    tbl[3]  = mk(0, 4'b0000, 32'h0,        1,  1, 2, 8'h12, 4'b1100, 0);
    tbl[4]  = mk(0, 4'b0000, 32'h0,        1,  1, 3, 8'h13, 4'b1000, 0);
    tbl[5]  = mk(0, 4'b0010, 32'h00000700, 0,  0, 0, 8'h00, 4'b0000, 0);
    tbl[6]  = mk(0, 4'b0010, 32'h00000800, 0,  1, 1, 8'h07, 4'b0010, 0);
    tbl[7]  = mk(0, 4'b0000, 32'h0,        0,  1, 1, 8'h07, 4'b0010, 0);
    tbl[8]  = mk(0, 4'b0001, 32'h00000020, 0,  1, 1, 8'h07, 4'b0010, 0);
    tbl[9]  = mk(0, 4'b0000, 32'h0,        0,  1, 1, 8'h07, 4'b0011, 0);
    tbl[10] = mk(0, 4'b0000, 32'h0,        1,  1, 1, 8'h07, 4'b0011, 0);
    tbl[11] = mk(0, 4'b0000, 32'h0,        1,  1, 0, 8'h20, 4'b0011, 0);
    tbl[12] = mk(0, 4'b0000, 32'h0,        1,  1, 1, 8'h08, 4'b0010, 0);
    tbl[13] = mk(0, 4'b0001, 32'h00000030, 0,  0, 0, 8'h00, 4'b0000, 0);
    tbl[14] = mk(0, 4'b0001, 32'h00000031, 0,  1, 0, 8'h30, 4'b0001, 0);
    tbl[15] = mk(0, 4'b0001, 32'h00000032, 0,  1, 0, 8'h30, 4'b0001, 0);
    tbl[16] = mk(0, 4'b0000, 32'h0,        0,  1, 0, 8'h30, 4'b0001, 1);
    tbl[17] = mk(0, 4'b0000, 32'h0,        1,  1, 0, 8'h30, 4'b0001, 1);
    tbl[18] = mk(0, 4'b0000, 32'h0,        1,  1, 0, 8'h31, 4'b0001, 1);
    tbl[19] = mk(0, 4'b0111, 32'h00424140, 0,  0, 0, 8'h00, 4'b0000, 1);
    tbl[20] = mk(1, 4'b1000, 32'h43000000, 1,  1, 1, 8'h41, 4'b0111, 1);
    tbl[21] = mk(0, 4'b0000, 32'h0,        1,  0, 0, 8'h00, 4'b0000, 1);
    tbl[22] = mk(0, 4'b0100, 32'h00500000, 0,  0, 0, 8'h00, 4'b0000, 1);
    tbl[23] = mk(0, 4'b0100, 32'h00510000, 0,  1, 2, 8'h50, 4'b0100, 1);
    tbl[24] = mk(0, 4'b0100, 32'h00520000, 1,  1, 2, 8'h50, 4'b0100, 1);
    tbl[25] = mk(0, 4'b0000, 32'h0,        1,  1, 2, 8'h51, 4'b0100, 1);
    tbl[26] = mk(0, 4'b0000, 32'h0,        1,  1, 2, 8'h52, 4'b0100, 1);
    tbl[27] = mk(0, 4'b0000, 32'h0,        1,  0, 0, 8'h00, 4'b0000, 1);

    // Reset state
    apply(0, 0, 4'b0000, 32'h0, 0);
    apply(0, 0, 4'b0000, 32'h0, 0);
    apply(0, 0, 4'b0000, 32'h0, 0);
    #1;
    chk("reset_valid", 128'(wb_valid), 128'(1'b0));
    chk("reset_af",    128'(af),       128'(4'b0000));
    chk("reset_src",   128'(src),      128'(2'd0));
    chk("reset_ovf",   128'(ovf),      128'(1'b0));

    for (int i = 0; i < NV; i++) begin
      apply(1, tbl[i].sq, tbl[i].v, tbl[i].ids, tbl[i].rdy);
      #1;
      chk($sformatf("v%0d_valid", i), 128'(wb_valid), 128'(tbl[i].ev));
      chk($sformatf("v%0d_af", i),    128'(af),       128'(tbl[i].eaf));
      chk($sformatf("v%0d_ovf", i),   128'(ovf),      128'(tbl[i].eovf));
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_src", i),     128'(src),    128'(tbl[i].esrc));
        chk($sformatf("v%0d_payload", i), 128'({wb}), 128'({mk_fu(tbl[i].eid)}));
      end
    end

    // Single result, bit-exact payload
    apply(1, 0, 4'b0100, 32'h00050000, 1);
    fu_in[2].rdval = 64'hdeadbeefdeadbeef;
    apply(1, 0, 4'b0000, 32'h0, 1);
    #1;
    chk("single_valid", 128'(wb_valid),  128'(1'b1));
    chk("single_src",   128'(src),       128'(2'd2));
    chk("single_id",    128'(wb.id),     128'(8'h05));
    chk("single_rdval", 128'(wb.rdval),  128'(64'hdeadbeefdeadbeef));
    chk("single_pc",    128'(wb.pc),     128'(32'h00400005));
    apply(1, 0, 4'b0000, 32'h0, 1);
    #1;
    chk("single_after", 128'(wb_valid),  128'(1'b0));

    // Reset mid-drain with an enqueue in the reset cycle
    apply(1, 0, 4'b0111, 32'h00727170, 0);
    apply(1, 0, 4'b0000, 32'h0, 1);
    #1;
    chk("pre_rst_src0", 128'(src), 128'(2'd0));
    apply(0, 0, 4'b1000, 32'h7f000000, 1);
    #1;
    chk("pre_rst_valid", 128'(wb_valid), 128'(1'b1));
    chk("pre_rst_src1",  128'(src),      128'(2'd1));
    apply(1, 0, 4'b1001, 32'h83000080, 0);
    #1;
    chk("post_rst_valid", 128'(wb_valid), 128'(1'b0));
    chk("post_rst_ovf",   128'(ovf),      128'(1'b0));
    chk("post_rst_af",    128'(af),       128'(4'b0000));
    chk("post_rst_src",   128'(src),      128'(2'd0));
    apply(1, 0, 4'b0000, 32'h0, 1);
    #1;
    chk("post_rst_g0_src", 128'(src),   128'(2'd0));
    chk("post_rst_g0_id",  128'(wb.id), 128'(8'h80));
    apply(1, 0, 4'b0000, 32'h0, 1);
    #1;
    chk("post_rst_g1_src", 128'(src),   128'(2'd3));
    chk("post_rst_g1_id",  128'(wb.id), 128'(8'h83));
    apply(1, 0, 4'b0000, 32'h0, 1);
    #1;
    chk("post_rst_empty", 128'(wb_valid), 128'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
